// File: rtl/systolic_pkg.sv
// Shared configuration and state encoding for the 3x3 systolic sequencer.
// Array geometry and PE latency live here so the top, feeder and interface agree.
package systolic_pkg;

    localparam int N         = 3;
    localparam int DW        = 8;
    localparam int PE_LAT    = 2;
    localparam int FEED_CYC  = 2 * N - 1;
    localparam int DRAIN_CYC = N - 1 + PE_LAT;
    localparam int CNT_W     = $clog2(2 * N + PE_LAT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        DRAIN,
        CAPTURE
    } state_t;

endpackage

// File: rtl/systolic_sequencer_if.sv
// Matrix-port and PE-mesh signal bundle for the systolic sequencer.
// master = environment (matrix source, PE mesh); slave = the sequencer.
interface systolic_sequencer_if;
    import systolic_pkg::*;

    logic                  START;
    logic [N*N*DW-1:0]     a_flat;
    logic [N*N*DW-1:0]     b_flat;
    logic [N*N*DW-1:0]     pe_result;
    logic [N*DW-1:0]       row_a;
    logic [N-1:0]          row_vld;
    logic [N*DW-1:0]       col_b;
    logic [N-1:0]          col_vld;
    logic                  pe_clear;
    logic                  busy;
    logic                  DONE;
    logic [N*N*DW-1:0]     m_flat;

    modport master (
        output START, a_flat, b_flat, pe_result,
        input  row_a, row_vld, col_b, col_vld, pe_clear, busy, DONE, m_flat
    );

    modport slave (
        input  START, a_flat, b_flat, pe_result,
        output row_a, row_vld, col_b, col_vld, pe_clear, busy, DONE, m_flat
    );

endinterface

// File: rtl/skew_feeder.sv
// Combinational wavefront select for one array edge: lane l carries element k = t-l.
// Rows read mat[l][k]; columns (IS_COL) read mat[k][l].
module skew_feeder
    import systolic_pkg::*;
#(
    parameter bit IS_COL = 1'b0
) (
    input  logic [CNT_W-1:0]   t,
    input  logic               en,
    input  logic [N*N*DW-1:0]  mat,
    output logic [N*DW-1:0]    data,
    output logic [N-1:0]       vld
);

    always_comb begin
        int k;
        k    = 0;
        data = '0;
        vld  = '0;
        for (int l = 0; l < N; l++) begin
            k = int'(t) - l;
            if (en && k >= 0 && k < N) begin
                vld[l] = 1'b1;
                if (IS_COL)
                    data[l*DW +: DW] = mat[(k*N + l)*DW +: DW];
                else
                    data[l*DW +: DW] = mat[(l*N + k)*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for the 3x3 systolic array: latches operands, drives skewed wavefronts,
// waits for the mesh to drain, captures the result matrix and pulses DONE.
module systolic_sequencer
    import systolic_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    systolic_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [N*N*DW-1:0]   a_sh, b_sh;
    logic [N*DW-1:0]     row_a_nx, col_b_nx;
    logic [N-1:0]        row_vld_nx, col_vld_nx;
    logic                feed_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE:    if (bus.START) state_nx = LOAD;
            LOAD: begin
                state_nx = FEED;
                cnt_nx   = '0;
            end
            FEED: begin
                if (cnt == FEED_LAST) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nx = CAPTURE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    assign feed_nx = (state_nx == FEED);

    skew_feeder #(.IS_COL(1'b0)) u_row_feeder (
        .t    (cnt_nx),
        .en   (feed_nx),
        .mat  (a_sh),
        .data (row_a_nx),
        .vld  (row_vld_nx)
    );

    skew_feeder #(.IS_COL(1'b1)) u_col_feeder (
        .t    (cnt_nx),
        .en   (feed_nx),
        .mat  (b_sh),
        .data (col_b_nx),
        .vld  (col_vld_nx)
    );

    // Shadow operands are captured on the accepting edge so FEED sees them from its first step.
    always_ff @(posedge CLK) begin
        if (state == IDLE && bus.START) begin
            a_sh <= bus.a_flat;
            b_sh <= bus.b_flat;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.row_a    <= '0;
            bus.row_vld  <= '0;
            bus.col_b    <= '0;
            bus.col_vld  <= '0;
            bus.pe_clear <= 1'b0;
            bus.busy     <= 1'b0;
            bus.DONE     <= 1'b0;
            bus.m_flat   <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            bus.row_a    <= row_a_nx;
            bus.row_vld  <= row_vld_nx;
            bus.col_b    <= col_b_nx;
            bus.col_vld  <= col_vld_nx;
            bus.pe_clear <= (state_nx == LOAD);
            bus.busy     <= (state_nx != IDLE);
            bus.DONE     <= (state == CAPTURE);
            if (state == CAPTURE)
                bus.m_flat <= bus.pe_result;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a behavioural PE mesh (MAC mod 2^DW,
// one-cycle operand hops, PE_LAT product pipeline).
module tb_systolic_sequencer;
    import systolic_pkg::*;

    localparam logic [N*N*DW-1:0] MAT_A = 72'h222120121110020100;
    localparam logic [N*N*DW-1:0] MAT_I = 72'h010000000100000001;
    localparam logic [N*N*DW-1:0] MAT_B = 72'h383736353433323130;

    localparam logic [N*DW-1:0] ROW_A_T [5] = '{24'h000000, 24'h001001, 24'h201102, 24'h211200, 24'h220000};
    localparam logic [N*DW-1:0] COL_I_T [5] = '{24'h000001, 24'h000000, 24'h000100, 24'h000000, 24'h010000};
    localparam logic [N*DW-1:0] COL_B_T [5] = '{24'h000030, 24'h003133, 24'h323436, 24'h353700, 24'h380000};
    localparam logic [N-1:0]    VLD_T   [5] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};

    logic CLK = 1'b0;
    logic RESET;
    int   n_run  = 0;
    int   n_fail = 0;

    systolic_sequencer_if bus ();

    systolic_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Behavioural PE mesh
    logic [DW-1:0] a_reg [N][N];
    logic [DW-1:0] b_reg [N][N];
    logic          av_reg [N][N];
    logic          bv_reg [N][N];
    logic [DW-1:0] a_in [N][N];
    logic [DW-1:0] b_in [N][N];
    logic          av_in [N][N];
    logic          bv_in [N][N];
    logic [DW-1:0] pipe [N][N][PE_LAT];
    logic [DW-1:0] acc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_in[i][j]  = (j == 0) ? bus.row_a[i*DW +: DW] : a_reg[i][(j > 0) ? j-1 : 0];
                av_in[i][j] = (j == 0) ? bus.row_vld[i]        : av_reg[i][(j > 0) ? j-1 : 0];
                b_in[i][j]  = (i == 0) ? bus.col_b[j*DW +: DW] : b_reg[(i > 0) ? i-1 : 0][j];
                bv_in[i][j] = (i == 0) ? bus.col_vld[j]        : bv_reg[(i > 0) ? i-1 : 0][j];
            end
        end
    end

    always_comb begin
        bus.pe_result = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                bus.pe_result[(i*N + j)*DW +: DW] = acc[i][j];
    end

    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_reg[i][j]  <= a_in[i][j];
                av_reg[i][j] <= av_in[i][j];
                b_reg[i][j]  <= b_in[i][j];
                bv_reg[i][j] <= bv_in[i][j];
                if (bus.pe_clear) begin
                    for (int l = 0; l < PE_LAT; l++) pipe[i][j][l] <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pipe[i][j][0] <= (av_in[i][j] && bv_in[i][j]) ? DW'(a_in[i][j] * b_in[i][j]) : '0;
                    for (int l = 1; l < PE_LAT; l++) pipe[i][j][l] <= pipe[i][j][l-1];
                    acc[i][j] <= acc[i][j] + pipe[i][j][PE_LAT-1];
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    // Drives START for one accepting edge; returns just after that edge (edge 0).
    task automatic launch(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b);
        bus.a_flat = a;
        bus.b_flat = b;
        bus.START  = 1'b1;
        tick();
        bus.START  = 1'b0;
    endtask

    task automatic test_reset();
        logic [N*N*DW+4*N*DW/DW+N*DW+3:0] outs;
        RESET     = 1'b1;
        bus.START = 1'b0;
        bus.a_flat = '0;
        bus.b_flat = '0;
        ticks(3);
        outs = {bus.row_a, bus.row_vld, bus.col_b, bus.col_vld, bus.pe_clear, bus.busy, bus.DONE, bus.m_flat};
        n_run++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_state outputs got %h required 0", outs);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_feed_skew();
        launch(MAT_A, MAT_I);
        n_run++;
        if (bus.pe_clear !== 1'b1 || bus.busy !== 1'b1 || bus.row_vld !== '0) begin
            n_fail++;
            $display("FAIL load_cycle clear/busy/vld got %b%b%b required 11000", bus.pe_clear, bus.busy, bus.row_vld);
        end
        for (int t = 0; t < FEED_CYC; t++) begin
            tick();
            n_run++;
            if (bus.row_a !== ROW_A_T[t] || bus.row_vld !== VLD_T[t]) begin
                n_fail++;
                $display("FAIL row_skew t=%0d got %h/%b required %h/%b", t, bus.row_a, bus.row_vld, ROW_A_T[t], VLD_T[t]);
            end
            n_run++;
            if (bus.col_b !== COL_I_T[t] || bus.col_vld !== VLD_T[t] || bus.pe_clear !== 1'b0) begin
                n_fail++;
                $display("FAIL col_skew_ident t=%0d got %h/%b clr=%b required %h/%b clr=0", t, bus.col_b, bus.col_vld, bus.pe_clear, COL_I_T[t], VLD_T[t]);
            end
        end
        ticks(7);
    endtask

    task automatic test_done_capture();
        launch(MAT_A, MAT_I);
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_run++;
            if (bus.DONE !== (c == 11) || bus.busy !== (c <= 10)) begin
                n_fail++;
                $display("FAIL done_timing edge=%0d got done=%b busy=%b required done=%b busy=%b", c, bus.DONE, bus.busy, (c == 11), (c <= 10));
            end
            if (c == 11) begin
                n_run++;
                if (bus.m_flat !== MAT_A) begin
                    n_fail++;
                    $display("FAIL capture_m_flat got %h required %h", bus.m_flat, MAT_A);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic seen_done;
        logic [N*N*DW+4*N*DW/DW+N*DW+3:0] outs;
        launch(MAT_A, MAT_I);
        ticks(3);
        n_run++;
        if (bus.busy !== 1'b1 || bus.row_vld !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_reset_feed got busy=%b vld=%b required busy=1 vld=111", bus.busy, bus.row_vld);
        end
        #1 RESET = 1'b1;
        #1;
        outs = {bus.row_a, bus.row_vld, bus.col_b, bus.col_vld, bus.pe_clear, bus.busy, bus.DONE, bus.m_flat};
        n_run++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs got %h required 0", outs);
        end
        tick();
        RESET = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.DONE === 1'b1 || bus.busy !== 1'b0) seen_done = 1'b1;
        end
        n_run++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort activity after reset got %b required 0", seen_done);
        end
        launch(MAT_A, MAT_I);
        ticks(11);
        n_run++;
        if (bus.DONE !== 1'b1 || bus.m_flat !== MAT_A) begin
            n_fail++;
            $display("FAIL rerun_after_reset got done=%b m=%h required done=1 m=%h", bus.DONE, bus.m_flat, MAT_A);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.a_flat = MAT_A;
        bus.b_flat = MAT_I;
        bus.START  = 1'b1;
        tick();
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (c == 12) bus.START = 1'b0;
            if (c == 18) bus.START = 1'b1;
            if (c == 19) bus.START = 1'b0;
            n_run++;
            if (bus.DONE !== (c == 11 || c == 23)) begin
                n_fail++;
                $display("FAIL b2b_done edge=%0d got %b required %b", c, bus.DONE, (c == 11 || c == 23));
            end
            if (c == 12) begin
                n_run++;
                if (bus.pe_clear !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_retrigger pe_clear got %b required 1", bus.pe_clear);
                end
            end
        end
        n_run++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle busy got %b required 0", bus.busy);
        end
    endtask

    task automatic test_input_change();
        launch(MAT_A, MAT_I);
        tick();
        bus.a_flat = '1;
        bus.b_flat = '1;
        ticks(2);
        n_run++;
        if (bus.row_a !== 24'h201102 || bus.col_b !== 24'h000100) begin
            n_fail++;
            $display("FAIL no_relatch t=2 got %h/%h required 201102/000100", bus.row_a, bus.col_b);
        end
        ticks(8);
        n_run++;
        if (bus.DONE !== 1'b1 || bus.m_flat !== MAT_A) begin
            n_fail++;
            $display("FAIL no_relatch_result got done=%b m=%h required done=1 m=%h", bus.DONE, bus.m_flat, MAT_A);
        end
        tick();
    endtask

    task automatic test_col_skew();
        launch(MAT_A, MAT_B);
        for (int t = 0; t < FEED_CYC; t++) begin
            tick();
            n_run++;
            if (bus.col_b !== COL_B_T[t] || bus.col_vld !== VLD_T[t]) begin
                n_fail++;
                $display("FAIL col_skew t=%0d got %h/%b required %h/%b", t, bus.col_b, bus.col_vld, COL_B_T[t], VLD_T[t]);
            end
        end
        for (int t = FEED_CYC; t < FEED_CYC + DRAIN_CYC; t++) begin
            tick();
            n_run++;
            if (bus.col_b !== '0 || bus.col_vld !== '0 || bus.row_a !== '0 || bus.row_vld !== '0) begin
                n_fail++;
                $display("FAIL drain_zero t=%0d got %h/%b %h/%b required all 0", t, bus.col_b, bus.col_vld, bus.row_a, bus.row_vld);
            end
        end
        ticks(3);
    endtask

    initial begin
        test_reset();
        test_feed_skew();
        test_done_capture();
        test_reset_mid_run();
        test_back_to_back();
        test_input_change();
        test_col_skew();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
